i2s_rx: RTL

//  I2S master receiver for the line-in side of the Pmod I2S2 (ADC). It generates mclk, lrck and sclk from clk and deserialises sd_in.

---
 rtl/i2s_pkg.sv | 22 ++
 rtl/i2s_clkgen.sv | 60 ++++++
 rtl/i2s_rx.sv | 129 ++++++++++++
 3 files changed

// File: rtl/i2s_pkg.sv
// ---------------------------------------------------------------------------
// i2s_pkg
// Shared constants and types for the Pmod I2S2 interface blocks.
//   DIV_BASE_DEF  default clock divider base (mclk = cnt[DIV_BASE])
//   SAMPLE_W_DEF  default bits kept per channel
//   DELAY_SLOT    I2S one-bit delay slot at the start of each half frame
//   SLOTS_PER_CH  sclk periods per channel half frame
//   stereo_t      left/right sample pair at the default width
// ---------------------------------------------------------------------------
package i2s_pkg;

    localparam int DIV_BASE_DEF = 2;
    localparam int SAMPLE_W_DEF = 16;
    localparam int DELAY_SLOT   = 0;
    localparam int SLOTS_PER_CH = 32;

    typedef struct packed {
        logic signed [SAMPLE_W_DEF-1:0] left;
        logic signed [SAMPLE_W_DEF-1:0] right;
    } stereo_t;

endpackage

// File: rtl/i2s_clkgen.sv
// ---------------------------------------------------------------------------
// i2s_clkgen
// Free-running frame counter for an I2S master plus registered pin clocks
// and the frame-timing strobes used by the receive datapath.
// Ports:
//   clk, rst      system clock, synchronous active-high reset
//   mclk/sclk/lrck registered copies of cnt[DIV_BASE], cnt[DIV_BASE+2],
//                 cnt[DIV_BASE+8]
//   slot          current bit slot within the half frame
//   sample_stb    mid sclk-high sampling point of the current slot
//   left_end      last cycle of the left half frame
//   right_end     last cycle of the right half frame (whole frame done)
// ---------------------------------------------------------------------------
module i2s_clkgen
    import i2s_pkg::*;
#(
    parameter int DIV_BASE = DIV_BASE_DEF
) (
    input  logic                            clk,
    input  logic                            rst,
    output logic                            mclk,
    output logic                            sclk,
    output logic                            lrck,
    output logic [$clog2(SLOTS_PER_CH)-1:0] slot,
    output logic                            sample_stb,
    output logic                            left_end,
    output logic                            right_end
);

    localparam int CNT_W  = DIV_BASE + 9;
    localparam int SLOT_W = $clog2(SLOTS_PER_CH);

    // Sampling phase inside one sclk period: 6/8 of the way, mid sclk-high.
    localparam int                  STB_PH_I = 6 << DIV_BASE;
    localparam logic [DIV_BASE+2:0] STB_PH   = STB_PH_I[DIV_BASE+2:0];
    localparam logic [CNT_W-1:0]    LEFT_END = {1'b0, {(CNT_W-1){1'b1}}};

    logic [CNT_W-1:0] cnt_p0;

    // Stage 0: frame counter and registered pin clocks
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_p0 <= '0;
            mclk   <= 1'b0;
            sclk   <= 1'b0;
            lrck   <= 1'b0;
        end else begin
            cnt_p0 <= cnt_p0 + 1'b1;
            mclk   <= cnt_p0[DIV_BASE];
            sclk   <= cnt_p0[DIV_BASE+2];
            lrck   <= cnt_p0[DIV_BASE+8];
        end
    end

    assign slot       = cnt_p0[DIV_BASE+7 -: SLOT_W];
    assign sample_stb = (cnt_p0[DIV_BASE+2:0] == STB_PH);
    assign left_end   = (cnt_p0 == LEFT_END);
    assign right_end  = &cnt_p0;

endmodule

// File: rtl/i2s_rx.sv
// ---------------------------------------------------------------------------
// i2s_rx
// I2S master receiver for the Pmod I2S2 line-in ADC. Generates mclk, sclk and
// lrck, deserialises sd_in and offers one signed stereo pair per frame on a
// valid/ready interface. A pair overwritten before acceptance sets the
// sticky overrun flag.
// Ports:
//   clk, rst              system clock, synchronous active-high reset
//   mclk, lrck, sclk      ADC clocks (lrck 0 = left, 1 = right)
//   sd_in                 ADC serial data
//   out_left, out_right   signed samples, SAMPLE_W bits, MSB-first truncated
//   out_valid, out_ready  pair handshake
//   overrun, overrun_clr  sticky overwrite flag and its clear (set wins)
// Optional build macro I2S_RX_MONO_EN adds out_mono = (left + right) >>> 1,
// floor rounding, registered alongside the stereo pair.
// ---------------------------------------------------------------------------
module i2s_rx
    import i2s_pkg::*;
#(
    parameter int SAMPLE_W = SAMPLE_W_DEF,
    parameter int DIV_BASE = DIV_BASE_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    output logic                       mclk,
    output logic                       lrck,
    output logic                       sclk,
    input  logic                       sd_in,
    output logic signed [SAMPLE_W-1:0] out_left,
    output logic signed [SAMPLE_W-1:0] out_right,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       overrun,
    input  logic                       overrun_clr
`ifdef I2S_RX_MONO_EN
    ,
    output logic signed [SAMPLE_W-1:0] out_mono
`endif
);

    localparam int SLOT_W = $clog2(SLOTS_PER_CH);

    logic [SLOT_W-1:0]          slot;
    logic                       sample_stb;
    logic                       left_end;
    logic                       right_end;
    logic                       data_slot;
    logic                       accept;
    logic                       sd_p0;
    logic signed [SAMPLE_W-1:0] shift_p1;
    logic signed [SAMPLE_W-1:0] left_hold_p1;

`ifdef I2S_RX_MONO_EN
    // Floor average: one extra bit of headroom, then drop the LSB.
    function automatic logic signed [SAMPLE_W-1:0] mono_avg(
        input logic signed [SAMPLE_W-1:0] l,
        input logic signed [SAMPLE_W-1:0] r
    );
        logic signed [SAMPLE_W:0] sum;
        sum = {l[SAMPLE_W-1], l} + {r[SAMPLE_W-1], r};
        return sum[SAMPLE_W:1];
    endfunction
`endif

    i2s_clkgen #(
        .DIV_BASE (DIV_BASE)
    ) u_clkgen (
        .clk        (clk),
        .rst        (rst),
        .mclk       (mclk),
        .sclk       (sclk),
        .lrck       (lrck),
        .slot       (slot),
        .sample_stb (sample_stb),
        .left_end   (left_end),
        .right_end  (right_end)
    );

    // Slot 0 is the I2S delay bit; ADC bits beyond SAMPLE_W are discarded.
    assign data_slot = (int'(slot) > DELAY_SLOT) && (int'(slot) <= DELAY_SLOT + SAMPLE_W);
    assign accept    = out_valid && out_ready;

    // Stage 0: input capture
    always_ff @(posedge clk) begin
        sd_p0 <= sd_in;
    end

    // Stage 1: deserialise; every data slot is rewritten each half frame,
    // so a reset needs no clearing here to discard a partial frame.
    always_ff @(posedge clk) begin
        if (sample_stb && data_slot) begin
            shift_p1 <= SAMPLE_W'({shift_p1, sd_p0});
        end
        if (left_end) begin
            left_hold_p1 <= shift_p1;
        end
    end

    // Stage 2: output pair and handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            out_left  <= '0;
            out_right <= '0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
`ifdef I2S_RX_MONO_EN
            out_mono  <= '0;
`endif
        end else begin
            if (right_end) begin
                out_left  <= left_hold_p1;
                out_right <= shift_p1;
                out_valid <= 1'b1;
`ifdef I2S_RX_MONO_EN
                out_mono  <= mono_avg(left_hold_p1, shift_p1);
`endif
            end else if (accept) begin
                out_valid <= 1'b0;
            end

            if (right_end && out_valid && !out_ready) begin
                overrun <= 1'b1;
            end else if (overrun_clr) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule
